// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the requesters, the data-memory arbiter and the memory.
//   cpu_*  : CPU load/store channel (byte address, RV32I funct3 size/sign code)
//   dma_*  : word-only loader/debug channel (dma_addr[1:0] ignored)
//   mem_*  : single-port synchronous memory, read data valid the cycle after mem_re
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned MEM_AW = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_funct3;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;

    logic              dma_req;
    logic              dma_we;
    logic [31:0]       dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_ready;
    logic [31:0]       dma_rdata;

    logic              mem_re;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_err,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_err,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter between a CPU (byte/half/word loads and
// stores, sub-word stores done as read-modify-write) and a word-only DMA port.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dmem_arbiter_if.slave carrying the cpu_*, dma_* and mem_* signals
// All outputs are registered; their next values are decoded from the next
// state and next latched request so they line up with the state they belong to.
module dmem_arbiter #(
    parameter int unsigned MEM_AW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        bus
);
    localparam int unsigned AW = MEM_AW + 2;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

    state_t            state, state_n;
    logic              lat_cpu, lat_cpu_n;
    logic              lat_we, lat_we_n;
    logic              lat_err, lat_err_n;
    logic [2:0]        lat_f3, lat_f3_n;
    logic [AW-1:0]     lat_addr, lat_addr_n;
    logic [31:0]       lat_wdata, lat_wdata_n;
    logic [31:0]       cap, cap_n;
    logic              dma_last, dma_last_n;
    logic              grant_cpu;

    logic              cpu_ready_n, dma_ready_n, cpu_err_n, mem_re_n, mem_we_n;
    logic [31:0]       cpu_rdata_n, dma_rdata_n, mem_wdata_n;
    logic [MEM_AW-1:0] mem_addr_n;

    // Address bits outside the memory window are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_addr[31:AW], bus.dma_addr[31:AW], bus.dma_addr[1:0]};

    // Illegal funct3 for the direction, or a misaligned half/word.
    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic e;
        e = 1'b1;
        case (f3)
            3'd0:    e = 1'b0;
            3'd1:    e = off[0];
            3'd2:    e = (off != 2'b00);
            3'd4:    e = we;
            3'd5:    e = we | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Merge store data into the captured word (word stores pass through).
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] w;
        w = old;
        case (f3[1:0])
            2'd0:    w[{off, 3'b000} +: 8]       = wd[7:0];
            2'd1:    w[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: w = wd;
        endcase
        return w;
    endfunction

    // Lane select plus sign/zero extension of a load.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] s;
        logic [31:0] r;
        s = w >> {off, 3'b000};
        case (f3)
            3'd0:    r = {{24{s[7]}}, s[7:0]};
            3'd1:    r = {{16{s[15]}}, s[15:0]};
            3'd2:    r = w;
            3'd4:    r = {24'd0, s[7:0]};
            3'd5:    r = {16'd0, s[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lat_cpu       <= 1'b0;
            lat_we        <= 1'b0;
            lat_err       <= 1'b0;
            lat_f3        <= 3'd0;
            lat_addr      <= '0;
            lat_wdata     <= 32'd0;
            cap           <= 32'd0;
            dma_last      <= 1'b1;
            bus.cpu_ready <= 1'b0;
            bus.cpu_rdata <= 32'd0;
            bus.cpu_err   <= 1'b0;
            bus.dma_ready <= 1'b0;
            bus.dma_rdata <= 32'd0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
        end else begin
            state         <= state_n;
            lat_cpu       <= lat_cpu_n;
            lat_we        <= lat_we_n;
            lat_err       <= lat_err_n;
            lat_f3        <= lat_f3_n;
            lat_addr      <= lat_addr_n;
            lat_wdata     <= lat_wdata_n;
            cap           <= cap_n;
            dma_last      <= dma_last_n;
            bus.cpu_ready <= cpu_ready_n;
            bus.cpu_rdata <= cpu_rdata_n;
            bus.cpu_err   <= cpu_err_n;
            bus.dma_ready <= dma_ready_n;
            bus.dma_rdata <= dma_rdata_n;
            bus.mem_re    <= mem_re_n;
            bus.mem_we    <= mem_we_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
        end
    end

    // Arbitration, next state and next output values.
    always_comb begin
        state_n     = state;
        lat_cpu_n   = lat_cpu;
        lat_we_n    = lat_we;
        lat_err_n   = lat_err;
        lat_f3_n    = lat_f3;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        cap_n       = cap;
        dma_last_n  = dma_last;
        grant_cpu   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    // CPU wins unless DMA also asks and the CPU had the last grant.
                    grant_cpu  = bus.cpu_req && (!bus.dma_req || dma_last);
                    lat_cpu_n  = grant_cpu;
                    dma_last_n = !grant_cpu;
                    if (grant_cpu) begin
                        lat_we_n    = bus.cpu_we;
                        lat_f3_n    = bus.cpu_funct3;
                        lat_addr_n  = bus.cpu_addr[AW-1:0];
                        lat_wdata_n = bus.cpu_wdata;
                        lat_err_n   = access_err(bus.cpu_we, bus.cpu_funct3, bus.cpu_addr[1:0]);
                    end else begin
                        lat_we_n    = bus.dma_we;
                        lat_f3_n    = 3'd2;
                        lat_addr_n  = {bus.dma_addr[AW-1:2], 2'b00};
                        lat_wdata_n = bus.dma_wdata;
                        lat_err_n   = 1'b0;
                    end
                    if (lat_err_n)
                        state_n = DONE;
                    else if (lat_we_n && (lat_f3_n == 3'd2))
                        state_n = WR;
                    else
                        state_n = RD;
                end
            end
            RD:   state_n = WAIT;
            WAIT: begin
                cap_n   = bus.mem_rdata;
                state_n = lat_we ? WR : DONE;
            end
            WR:   state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        mem_re_n    = (state_n == RD);
        mem_we_n    = (state_n == WR);
        mem_addr_n  = lat_addr_n[AW-1:2];
        mem_wdata_n = (state_n == WR) ? merge(cap_n, lat_wdata_n, lat_f3_n, lat_addr_n[1:0]) : 32'd0;
        cpu_ready_n = (state_n == DONE) && lat_cpu_n;
        dma_ready_n = (state_n == DONE) && !lat_cpu_n;
        cpu_err_n   = cpu_ready_n && lat_err_n;
        cpu_rdata_n = (cpu_ready_n && !lat_err_n && !lat_we_n)
                      ? load_ext(cap_n, lat_f3_n, lat_addr_n[1:0]) : 32'd0;
        dma_rdata_n = (dma_ready_n && !lat_we_n) ? cap_n : 32'd0;
    end
endmodule
